pre_full_adder1: RTL and testbench
==================================

Name: pre_full_adder1

Overview:
4-bit carry-lookahead full adder with registered outputs: F = A + B + CIN, carry out on COUT. Per-bit propagate/generate, lookahead carry network and group P/G are computed combinationally, then captured in an output register. Used as a leaf arithmetic cell; group P/G outputs allow cascading into wider lookahead adders.

Parameters:
None. Width is fixed at 4 bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
A  input  4  addend A, unsigned (two's complement for OVF)
B  input  4  addend B
CIN  input  1  carry in
F  output  4  registered sum bits [3:0]
COUT  output  1  registered carry out of bit 3
GP  output  1  registered group propagate (P3&P2&P1&P0)
GG  output  1  registered group generate
OUT_VALID  output  1  high once the registers hold a computed result

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Per bit i: Pi = Ai ^ Bi, Gi = Ai & Bi.
- Lookahead carries, flattened, no ripple chain:
  - C0 = CIN
  - C1 = G0 | P0·C0
  - C2 = G1 | P1·G0 | P1·P0·C0
  - C3 = G2 | P2·G1 | P2·P1·G0 | P2·P1·P0·C0
  - C4 = G3 | P3·G2 | P3·P2·G1 | P3·P2·P1·G0 | P3·P2·P1·P0·C0
- Sum: Fi = Pi ^ Ci. COUT = C4.
- Group signals: GG = C4 evaluated with C0 = 0; GP = P3·P2·P1·P0.
- Invariant: {COUT,F} == A + B + CIN (5-bit unsigned) for all 512 input combinations.
- Latency: exactly 1 clock. Inputs sampled on a rising clk edge appear on F/COUT/GP/GG after that edge. New operands accepted every cycle; no handshake or stall.
- Reset while rst_n = 0, asynchronous and immediate:
  - F = 0, COUT = 0, GP = 0, GG = 0, OUT_VALID = 0.
  - All register outputs are held at these values.
- After rst_n deasserts, the first rising edge loads a result and sets OUT_VALID = 1. OUT_VALID stays 1 until the next reset.
- Reset mid-operation: outputs clear immediately and the in-flight result is discarded.
- Wrap-around: A = 4'hF, B = 4'h0, CIN = 1 → F = 0, COUT = 1.
- All-ones: A = B = 4'hF, CIN = 1 → F = 4'hF, COUT = 1.
- X/Z on inputs is not handled. Inputs are treated as synchronous to clk.

Optional Feature:
PREFULLADDER1_OVF_EN
- When defined: adds output port OVF (1 bit), registered alongside F.
  - OVF = C4 ^ C3, i.e. two's-complement signed overflow.
  - Reset value of OVF is 0.
- When undefined: the OVF port and its register are absent. All other behaviour is identical.

Test Plan:
- rst_n = 0 with A = 4'h5, B = 4'h3 applied → F = 0, COUT = 0, OUT_VALID = 0 immediately, no clock edge needed.
- Release reset; A = 0, B = 0, CIN = 0, one edge → F = 4'h0, COUT = 0, GP = 0, GG = 0, OUT_VALID = 1.
- A = 4'h7, B = 4'h8, CIN = 1, one edge → F = 4'h0, COUT = 1, GP = 1, GG = 0.
- A = 4'h5, B = 4'h3, CIN = 0 → F = 4'h8, COUT = 0; with PREFULLADDER1_OVF_EN, OVF = 1.
- Exhaustive sweep of all 512 (A, B, CIN) combinations, one per cycle → each result matches A + B + CIN one cycle later.
- Assert rst_n low mid-sweep, between edges → outputs drop to 0 asynchronously. After release, the first edge yields the correct sum for the current inputs.

Source files
------------

// File: rtl/pre_full_adder1.sv
// 4-bit carry-lookahead adder with registered sum, carry and group P/G.
// Define PREFULLADDER1_OVF_EN to add a registered signed-overflow output OVF.

module pre_full_adder1_pg (
  input  logic a,
  input  logic b,
  output logic p,
  output logic g
);
  assign p = a ^ b;
  assign g = a & b;
endmodule

module pre_full_adder1 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CIN,
  output logic [3:0] F,
  output logic       COUT,
  output logic       GP,
  output logic       GG,
  output logic       OUT_VALID
`ifdef PREFULLADDER1_OVF_EN
  , output logic     OVF
`endif
);
  localparam int NUM_BITS = 4;

  logic [NUM_BITS-1:0] p, g, sum;
  logic [NUM_BITS:0]   c;
  logic                gp_c, gg_c;

  for (genvar i = 0; i < NUM_BITS; i++) begin : g_pg
    pre_full_adder1_pg u_pg (.a(A[i]), .b(B[i]), .p(p[i]), .g(g[i]));
  end

  // Two-level carry terms; no carry depends on a lower computed carry.
  always_comb begin
    c[0] = CIN;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum  = p ^ c[NUM_BITS-1:0];
    gp_c = &p;
    gg_c = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F         <= '0;
      COUT      <= 1'b0;
      GP        <= 1'b0;
      GG        <= 1'b0;
      OUT_VALID <= 1'b0;
    end else begin
      F         <= sum;
      COUT      <= c[4];
      GP        <= gp_c;
      GG        <= gg_c;
      OUT_VALID <= 1'b1;
    end
  end

`ifdef PREFULLADDER1_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) OVF <= 1'b0;
    else        OVF <= c[4] ^ c[3];
  end
`endif

endmodule

// File: tb/tb_pre_full_adder1.sv
// Directed and exhaustive checks of pre_full_adder1 against hand-computed values.

module tb_pre_full_adder1;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] A = '0, B = '0;
  logic       CIN = 1'b0;
  logic [3:0] F;
  logic       COUT, GP, GG, OUT_VALID;
`ifdef PREFULLADDER1_OVF_EN
  logic       OVF;
`endif

  int checks = 0;
  int errors = 0;

  pre_full_adder1 dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .CIN(CIN),
    .F(F), .COUT(COUT), .GP(GP), .GG(GG), .OUT_VALID(OUT_VALID)
`ifdef PREFULLADDER1_OVF_EN
    , .OVF(OVF)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci);
    A = a; B = b; CIN = ci;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] exp_sum;
    logic [3:0] a, b;
    logic       ci;

    // Async reset with operands applied, no clock edge.
    A = 4'h5; B = 4'h3;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_F", {4'h0, F}, 8'h00);
    chk("rst_COUT", {7'h0, COUT}, 8'h00);
    chk("rst_GPGG", {6'h0, GP, GG}, 8'h00);
    chk("rst_VALID", {7'h0, OUT_VALID}, 8'h00);
    @(posedge clk); #1;
    chk("rst_hold", {3'h0, OUT_VALID, COUT, F}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    drive(4'h0, 4'h0, 1'b0);
    chk("zero_sum", {3'h0, COUT, F}, 8'h00);
    chk("zero_GPGG", {6'h0, GP, GG}, 8'h00);
    chk("zero_VALID", {7'h0, OUT_VALID}, 8'h01);

    drive(4'h7, 4'h8, 1'b1);
    chk("78c_sum", {3'h0, COUT, F}, 8'h10);
    chk("78c_GPGG", {6'h0, GP, GG}, 8'h02);

    drive(4'h5, 4'h3, 1'b0);
    chk("53_sum", {3'h0, COUT, F}, 8'h08);
    chk("53_GPGG", {6'h0, GP, GG}, 8'h00);
`ifdef PREFULLADDER1_OVF_EN
    chk("53_OVF", {7'h0, OVF}, 8'h01);
`endif

    drive(4'hF, 4'h0, 1'b1);
    chk("wrap_sum", {3'h0, COUT, F}, 8'h10);
    chk("wrap_GPGG", {6'h0, GP, GG}, 8'h02);

    drive(4'hF, 4'hF, 1'b1);
    chk("ones_sum", {3'h0, COUT, F}, 8'h1F);
    chk("ones_GPGG", {6'h0, GP, GG}, 8'h01);

    drive(4'hC, 4'h4, 1'b0);
    chk("c4_GPGG", {6'h0, GP, GG}, 8'h01);

    // Exhaustive sweep, with a mid-sweep async reset.
    for (int i = 0; i < 512; i++) begin
      a = i[8:5]; b = i[4:1]; ci = i[0];
      drive(a, b, ci);
      exp_sum = {1'b0, a} + {1'b0, b} + {4'h0, ci};
      chk("sweep_sum", {3'h0, COUT, F}, {3'h0, exp_sum});
      chk("sweep_GP", {7'h0, GP}, {7'h0, &(a ^ b)});
      chk("sweep_GG", {7'h0, GG}, {7'h0, (({1'b0, a} + {1'b0, b}) > 5'd15)});
`ifdef PREFULLADDER1_OVF_EN
      chk("sweep_OVF", {7'h0, OVF}, {7'h0, (a[3] == b[3]) && (exp_sum[3] != a[3])});
`endif
      if (i == 300) begin
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", {2'h0, OUT_VALID, GP, GG, COUT, F[1:0]} | {4'h0, F}, 8'h00);
        @(posedge clk); #1;
        chk("mid_rst_hold", {3'h0, OUT_VALID, COUT, F}, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_sum", {3'h0, COUT, F}, {3'h0, exp_sum});
        chk("post_rst_VALID", {7'h0, OUT_VALID}, 8'h01);
      end
    end
    chk("end_VALID", {7'h0, OUT_VALID}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
